// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port (we / A3 / WD3) between the
//   pipeline WB stage and a multi-cycle result source (mul/div, late loads).
//   WB has fixed priority and zero latency. Multi-cycle results are queued in
//   a small FIFO and drained into write slots that WB leaves idle. A wait
//   counter on the queue head forces a one-cycle WB stall so that queued
//   results cannot starve behind a continuously writing pipeline.
//
//   A WB write squashes (marks dead) every queued entry with the same
//   destination, because queued results are always older than the WB
//   instruction. Dead entries still occupy a drain slot but do not write.
//
// Parameters:
//   DEPTH     queue entries, power of 2, >= 2
//   MAX_WAIT  cycles a non-empty queue head may wait before wb_stall, >= 1
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   asynchronous active-high reset
//   wb_we     in   WB stage write request
//   wb_addr   in   WB destination register (5)
//   wb_data   in   WB write data (32)
//   mc_valid  in   multi-cycle result valid
//   mc_ready  out  queue can accept (= !full, not pop-aware)
//   mc_addr   in   multi-cycle destination register (5)
//   mc_data   in   multi-cycle write data (32)
//   wb_stall  out  pipeline must hold its WB instruction this cycle
//   rf_we     out  register-file write enable
//   rf_wa     out  register-file write address (5)
//   rf_wd     out  register-file write data (32)
//   fifo_cnt  out  number of queued entries
//   pending   out  (only with RF_WB_SCOREBOARD_EN) bit r set iff a live queued
//                  entry targets register r; registered
//
// Configuration macro:
//   RF_WB_SCOREBOARD_EN  adds the pending[31:0] scoreboard output.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_addr,
  input  logic [31:0]                wb_data,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [4:0]                 mc_addr,
  input  logic [31:0]                mc_data,
  output logic                       wb_stall,
  output logic                       rf_we,
  output logic [4:0]                 rf_wa,
  output logic [31:0]                rf_wd,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
`ifdef RF_WB_SCOREBOARD_EN
  ,
  output logic [31:0]                pending
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  // Queue storage
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WW-1:0]    r_wait;

  logic             w_empty;
  logic             w_full;
  logic             w_stall;
  logic             w_wb_eff;
  logic             w_push;
  logic             w_pop;
  logic             w_new_live;
  logic             w_head_live;
  logic [4:0]       w_head_addr;
  logic [31:0]      w_head_data;
  logic [DEPTH-1:0] w_push_sel;
  logic [DEPTH-1:0] w_pop_sel;
  logic [DEPTH-1:0] w_squash;
  logic [DEPTH-1:0] w_live_next;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_FULL);
  assign w_stall  = (r_wait == WAIT_SAT);
  assign w_wb_eff = wb_we && (wb_addr != 5'd0) && !w_stall;

  // r0 results are accepted (handshake completes) but never stored
  assign w_push   = mc_valid && !w_full && (mc_addr != 5'd0);
  // Head drains only in slots WB does not use (including forced stall slots)
  assign w_pop    = !w_wb_eff && !w_empty;
  // An entry enqueued alongside a WB write to the same register is born dead
  assign w_new_live = !(w_wb_eff && (mc_addr == wb_addr));

  assign w_head_live = r_live[r_rd_ptr];
  assign w_head_addr = r_addr[r_rd_ptr];
  assign w_head_data = r_data[r_rd_ptr];

  assign mc_ready = !w_full;
  assign wb_stall = w_stall;
  assign fifo_cnt = r_cnt;

  // Per-entry select, squash and next-live terms. Push and pop never hit the
  // same slot (push needs !full, pop needs !empty), and pop and squash are
  // mutually exclusive because pop requires !wb_eff.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign w_push_sel[gi]  = w_push && (r_wr_ptr == PW'(gi));
    assign w_pop_sel[gi]   = w_pop  && (r_rd_ptr == PW'(gi));
    assign w_squash[gi]    = w_wb_eff && (r_addr[gi] == wb_addr);
    assign w_live_next[gi] = w_push_sel[gi] ? w_new_live :
                             (w_pop_sel[gi] || w_squash[gi]) ? 1'b0 : r_live[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      r_live <= w_live_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push_sel[i]) begin
          r_addr[i] <= mc_addr;
          r_data[i] <= mc_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_wait   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // Head age: restarts whenever the head changes or there is no head
      if (w_pop || w_empty) begin
        r_wait <= '0;
      end else if (r_wait != WAIT_SAT) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  // Write-port mux. Reset forces the port quiet even if WB is requesting.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (!rst) begin
      if (w_wb_eff) begin
        rf_we = 1'b1;
        rf_wa = wb_addr;
        rf_wd = wb_data;
      end else if (!w_empty) begin
        rf_we = w_head_live;
        rf_wa = w_head_addr;
        rf_wd = w_head_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] r_pending;
  logic [31:0] w_pending_next;

  // Built from the next-state queue so the scoreboard moves on the same edge
  always_comb begin
    w_pending_next = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_next[i]) begin
        w_pending_next[w_push_sel[i] ? mc_addr : r_addr[i]] = 1'b1;
      end
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          mc_valid;
  logic          mc_ready;
  logic [4:0]    mc_addr;
  logic [31:0]   mc_data;
  logic          wb_stall;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [CW-1:0] fifo_cnt;
`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0]   pending;
`endif

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .mc_valid (mc_valid),
    .mc_ready (mc_ready),
    .mc_addr  (mc_addr),
    .mc_data  (mc_data),
    .wb_stall (wb_stall),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .fifo_cnt (fifo_cnt)
`ifdef RF_WB_SCOREBOARD_EN
    ,
    .pending  (pending)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: ordered list of queued results plus the head's age,
  // and the register file contents implied by the specified write rules.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          m_wait;
  logic [31:0] m_rf   [32];
  logic [31:0] rf_obs [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    mc_valid = mv;
    mc_addr  = ma;
    mc_data  = md;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic model_check();
    bit          st;
    bit          eff;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ep;
    st  = (m_wait >= MAX_WAIT);
    eff = !rst && wb_we && (wb_addr != 5'd0) && !st;
    ew = 1'b0; ea = 5'd0; ed = 32'd0;
    if (!rst) begin
      if (eff) begin
        ew = 1'b1; ea = wb_addr; ed = wb_data;
      end else if (mq.size() > 0) begin
        ew = mq[0].live; ea = mq[0].addr; ed = mq[0].data;
      end
    end
    chk("rf_we", rf_we, ew);
    chk("rf_wa", rf_wa, ea);
    chk("rf_wd", rf_wd, ed);
    chk("wb_stall", wb_stall, st);
    chk("mc_ready", mc_ready, mq.size() < DEPTH);
    chk("fifo_cnt", fifo_cnt, mq.size());
    ep = 32'd0;
    foreach (mq[i]) if (mq[i].live) ep[mq[i].addr] = 1'b1;
`ifdef RF_WB_SCOREBOARD_EN
    chk("pending", pending, ep);
`endif
    if (!rst && rf_we === 1'b1) rf_obs[rf_wa] = rf_wd;
  endtask

  task automatic model_edge();
    bit   st, eff, was_empty, pop, accept;
    ent_t h;
    st        = (m_wait >= MAX_WAIT);
    eff       = wb_we && (wb_addr != 5'd0) && !st;
    was_empty = (mq.size() == 0);
    pop       = !eff && !was_empty;
    accept    = mc_valid && (mq.size() < DEPTH);
    if (eff) begin
      m_rf[wb_addr] = wb_data;
      foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 0;
    end
    if (pop) begin
      h = mq.pop_front();
      if (h.live) m_rf[h.addr] = h.data;
    end
    if (accept && mc_addr != 5'd0) begin
      h.addr = mc_addr;
      h.data = mc_data;
      h.live = !(eff && mc_addr == wb_addr);
      mq.push_back(h);
    end
    if (was_empty || pop) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
  endtask

  task automatic settle_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    drive(we, wa, wd, mv, ma, md);
    settle_check();
    tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = 32'd0;
      rf_obs[r] = 32'd0;
    end
    model_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) begin
      settle_check();
      tick();
    end
    rst = 1'b0;

    // Test 1: WB direct write, then r0 write suppressed
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t1_we", rf_we, 1'b1);
    chk("t1_wa", rf_wa, 5'd8);
    chk("t1_wd", rf_wd, 32'hDEADBEEF);
    tick();
    drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t1_r0_we", rf_we, 1'b0);
    tick();

    // Test 2: one queued result drains in the next idle slot
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t2_we", rf_we, 1'b1);
    chk("t2_wa", rf_wa, 5'd9);
    chk("t2_wd", rf_wd, 32'h1234);
    tick();
    settle_check();
    chk("t2_cnt", fifo_cnt, 0);
    tick();

    // Test 3: continuous WB, anti-starvation stall after MAX_WAIT cycles
    cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd10, 32'h3333);
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive(1'b1, 5'(4 + i), $urandom, 1'b0, 5'd0, 32'd0);
      settle_check();
      chk("t3_nostall", wb_stall, 1'b0);
      tick();
    end
    drive(1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t3_stall", wb_stall, 1'b1);
    chk("t3_we", rf_we, 1'b1);
    chk("t3_wa", rf_wa, 5'd10);
    chk("t3_wd", rf_wd, 32'h3333);
    tick();
    drive(1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t3_unstall", wb_stall, 1'b0);
    chk("t3_cnt", fifo_cnt, 0);
    tick();

    // Test 4: queue fills, third push refused
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(13 + i), $urandom, 1'b1, 5'(16 + i), 32'(32'h1600 + i));
      settle_check();
      chk("t4_ready", mc_ready, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    drive(1'b1, 5'd19, 32'h19, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t4_cnt", fifo_cnt, 2);
    tick();
    repeat (3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t4_r18_unwritten", rf_obs[18], 32'd0);

    // Test 5: younger WB write squashes a queued result for the same register
    cycle(1'b1, 5'd7, 32'h7777, 1'b1, 5'd5, 32'hAAAA);
    drive(1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd0, 32'd0);
    settle_check();
`ifdef RF_WB_SCOREBOARD_EN
    chk("t5_pend_set", pending[5], 1'b1);
`endif
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle_check();
    chk("t5_dead_we", rf_we, 1'b0);
    chk("t5_cnt", fifo_cnt, 1);
`ifdef RF_WB_SCOREBOARD_EN
    chk("t5_pend_clr", pending[5], 1'b0);
`endif
    tick();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_r5", rf_obs[5], 32'hBBBB);

    // Test 6: reset in the middle of a drain
    cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h2121);
    cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h2323);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_cnt", fifo_cnt, 0);
    chk("t6_ready", mc_ready, 1'b1);
    chk("t6_stall", wb_stall, 1'b0);
    chk("t6_we", rf_we, 1'b0);
    settle_check();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) begin
      settle_check();
      chk("t6_no_write", rf_we, 1'b0);
      tick();
    end
    chk("t6_r23", rf_obs[23], 32'd0);

    // Randomized traffic on a small register range to exercise squashes
    repeat (600) begin
      cycle($urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (6) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int r = 0; r < 32; r++) chk("rf_final", rf_obs[r], m_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
